// File: rtl/command_rx_fifo.sv
// SPI (mode 0) byte receiver feeding a circular command FIFO for the control unit.
// The SPI inputs are synchronized into clk. The FIFO head is held in a register,
// and bytes that arrive while the FIFO is full are counted as dropped.
module command_rx_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_sck,
    input  logic                     spi_mosi,
    input  logic                     spi_cs_n,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     next,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [7:0]               drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    // Synchronizer chains; r_warm marks when the chains hold real samples after reset
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_warm;

    logic       r_sck_prev;
    logic       r_armed;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_rx_byte;
    logic       r_push;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_out_valid;
    logic [7:0]    r_out_byte;
    logic          r_overflow;
    logic [7:0]    r_drop_count;

    logic          w_sck;
    logic          w_mosi;
    logic          w_cs_n;
    logic          w_warm;
    logic          w_rise;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_drop;
    logic [AW-1:0] w_rd_ptr_inc;
    logic [LW-1:0] w_level_nxt;
    logic [7:0]    w_head_nxt;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_warm = r_warm[SYNC_STAGES-1];
    assign w_rise = w_sck & ~r_sck_prev & ~w_cs_n & r_armed;

    // Shift the asynchronous SPI pins through the synchronizer flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_warm      <= '0;
        end else begin
            r_sck_sync[0]  <= spi_sck;
            r_mosi_sync[0] <= spi_mosi;
            r_cs_sync[0]   <= spi_cs_n;
            r_warm[0]      <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sck_sync[i]  <= r_sck_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_warm[i]      <= r_warm[i-1];
            end
        end
    end

    // Byte assembly; a frame is only accepted once CS has been seen high since reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_prev <= 1'b0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_rx_byte  <= 8'd0;
            r_push     <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_sck_prev <= w_sck;
            if (w_warm && w_cs_n) begin
                r_armed <= 1'b1;
            end
            if (w_cs_n || !r_armed) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'd0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[6:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_byte <= {r_shift[6:0], w_mosi};
                    r_push    <= 1'b1;
                end
            end
        end
    end

    // FIFO control: pop/push qualification, next level and next registered head
    always_comb begin
        w_pop        = next & r_out_valid;
        w_full       = (r_level == LW'(DEPTH));
        w_wr         = r_push & (~w_full | w_pop);
        w_drop       = r_push & w_full & ~w_pop;
        w_rd_ptr_inc = r_rd_ptr + AW'(1);
        w_level_nxt  = r_level + LW'(w_wr) - LW'(w_pop);
        w_head_nxt   = r_out_byte;
        if (w_pop && (r_level > LW'(1))) begin
            w_head_nxt = r_mem[w_rd_ptr_inc];
        end else if (w_wr && ((r_level == LW'(0)) || ((r_level == LW'(1)) && w_pop))) begin
            w_head_nxt = r_rx_byte;
        end
    end

    // FIFO storage, written only when a byte is accepted
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_rx_byte;
        end
    end

    // FIFO pointers, level and registered head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'd0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_level     <= w_level_nxt;
            r_out_valid <= (w_level_nxt != LW'(0));
            r_out_byte  <= w_head_nxt;
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow) begin
                r_drop_count <= 8'd1;
            end else if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end
    end

    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign fill_level = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_command_rx_fifo.sv
// Randomized scoreboard bench for command_rx_fifo with a queue-based reference model.
module tb_command_rx_fifo;

    localparam int unsigned DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   spi_sck;
    logic                   spi_mosi;
    logic                   spi_cs_n;
    logic [7:0]             out_byte;
    logic                   out_valid;
    logic                   next;
    logic [$clog2(DEPTH):0] fill_level;
    logic                   overflow;
    logic                   clear_overflow;
    logic [7:0]             drop_count;

    command_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_cs_n       (spi_cs_n),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .next           (next),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 4;

    // Reference model: FIFO contents, sticky overflow, saturating drop counter
    logic [7:0] model_q[$];
    logic       m_ovf   = 1'b0;
    int         m_drops = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) begin
            model_q.push_back(b);
        end else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
    endtask

    task automatic check_state(input string name);
        chk({name, "_fill"}, int'(fill_level), model_q.size());
        chk({name, "_valid"}, int'(out_valid), int'(model_q.size() != 0));
        chk({name, "_ovf"}, int'(overflow), int'(m_ovf));
        chk({name, "_drops"}, int'(drop_count), m_drops);
        if (model_q.size() != 0) chk({name, "_head"}, int'(out_byte), int'(model_q[0]));
    endtask

    // Monitor: every accepted pop must present the model's oldest byte
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (reset && next && out_valid) begin
                if (model_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no valid data at %0t", out_byte, $time);
                end else begin
                    exp_b = model_q.pop_front();
                    chk("pop_data", int'(out_byte), int'(exp_b));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        repeat (4) cyc();
        spi_sck = 1'b1;
        repeat (4) cyc();
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        spi_cs_n = 1'b0;
        repeat (2) cyc();
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
        repeat (2) cyc();
        spi_cs_n = 1'b1;
        repeat (4) cyc();
        model_push(b);
    endtask

    // Last bit sent with the clk phase of the push strobe known; mode 0 measures it,
    // mode 1 aligns a pop with it, mode 2 aligns a clear_overflow with it
    task automatic send_byte_timed(input logic [7:0] b, input int mode);
        int k;
        spi_cs_n = 1'b0;
        repeat (2) cyc();
        for (int i = 7; i >= 1; i--) spi_bit(b[i]);
        spi_mosi = b[0];
        repeat (4) cyc();
        spi_sck = 1'b1;
        if (mode == 0) begin
            k = 0;
            while (!out_valid && k < 20) begin
                cyc();
                k++;
            end
            if (!out_valid) begin
                n_checks++;
                n_fail++;
                $display("FAIL push_timeout: out_valid still 0 after %0d cycles, expected 1", k);
            end else begin
                lat = k;
            end
            repeat (4) cyc();
        end else begin
            repeat (lat - 1) cyc();
            if (mode == 1) next = 1'b1;
            else clear_overflow = 1'b1;
            cyc();
            next = 1'b0;
            clear_overflow = 1'b0;
            repeat (4) cyc();
        end
        spi_sck = 1'b0;
        repeat (2) cyc();
        spi_cs_n = 1'b1;
        repeat (4) cyc();
        if (mode == 2) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end
        model_push(b);
    endtask

    task automatic pop();
        next = 1'b1;
        cyc();
        next = 1'b0;
        cyc();
    endtask

    task automatic abort_frame(input int nbits);
        spi_cs_n = 1'b0;
        repeat (2) cyc();
        for (int i = 0; i < nbits; i++) spi_bit(1'($urandom_range(0, 1)));
        repeat (2) cyc();
        spi_cs_n = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic clear_ovf();
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        m_ovf = 1'b0;
        m_drops = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        next = 1'b0;
        clear_overflow = 1'b0;
        #1;
        chk("rst_fill", int'(fill_level), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_byte", int'(out_byte), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drops", int'(drop_count), 0);
        repeat (3) cyc();
        reset = 1'b1;
        repeat (6) cyc();

        // Single byte
        send_byte_timed(8'hA5, 0);
        check_state("single");
        chk("single_byte", int'(out_byte), 8'hA5);
        pop();
        check_state("single_pop");

        // Burst of five, popped two cycles apart
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        check_state("burst");
        chk("burst_fill", int'(fill_level), 5);
        for (int i = 0; i < 5; i++) pop();
        check_state("burst_drain");

        // Aborted partial frame followed by a full byte
        abort_frame(5);
        check_state("abort_partial");
        send_byte(8'h3C);
        check_state("abort_byte");
        chk("abort_head", int'(out_byte), 8'h3C);
        pop();

        // Overflow: 18 bytes into 16 entries
        for (int i = 0; i < 18; i++) send_byte(8'(8'h10 + i));
        check_state("ovf");
        chk("ovf_drops", int'(drop_count), 2);
        chk("ovf_head", int'(out_byte), 8'h10);
        clear_ovf();
        check_state("ovf_clear");

        // Full FIFO: pop aligned with push keeps it full, no drop
        send_byte_timed(8'hEE, 1);
        check_state("full_pushpop");
        chk("full_pushpop_fill", int'(fill_level), 16);
        // Full FIFO: drop beats a same-cycle clear
        send_byte_timed(8'h99, 2);
        check_state("drop_vs_clear");
        clear_ovf();
        for (int i = 0; i < 16; i++) pop();
        check_state("full_drain");

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) send_byte(8'($urandom_range(0, 255)));
            else if (r < 7) pop();
            else if (r == 7) abort_frame(int'($urandom_range(1, 7)));
            else if (r == 8) clear_ovf();
            else check_state("rand");
        end
        check_state("rand_end");
        while (model_q.size() != 0) pop();
        check_state("rand_drain");

        // Asynchronous reset mid-frame with seven entries stored
        for (int i = 0; i < 7; i++) send_byte(8'(8'h40 + i));
        check_state("pre_reset");
        spi_cs_n = 1'b0;
        repeat (2) cyc();
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        model_q.delete();
        m_ovf = 1'b0;
        m_drops = 0;
        chk("async_rst_fill", int'(fill_level), 0);
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_byte", int'(out_byte), 0);
        repeat (2) cyc();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        repeat (2) cyc();
        spi_cs_n = 1'b1;
        repeat (4) cyc();
        check_state("post_reset");
        send_byte(8'h7E);
        check_state("post_reset_byte");
        chk("post_reset_head", int'(out_byte), 8'h7E);
        pop();
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/command_rx_fifo.md
COMMAND_RX_FIFO -- requirements
Module: command_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes; a power of two, at least 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each SPI input.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port spi_sck, input, 1 bit: SPI clock, asynchronous to clk (mode 0).
REQ-006 SHALL have port spi_mosi, input, 1 bit: SPI data, MSB first, asynchronous.
REQ-007 SHALL have port spi_cs_n, input, 1 bit: SPI chip select, active-low, asynchronous.
REQ-008 SHALL have port out_byte, output, 8 bits: head-of-FIFO byte, which drives the control unit's in_byte.
REQ-009 SHALL have port out_valid, output, 1 bit: FIFO non-empty, which drives the control unit's in_valid.
REQ-010 SHALL have port next, input, 1 bit: single-cycle pop strobe from the control unit.
REQ-011 SHALL have port fill_level, output, $clog2(DEPTH)+1 bits: number of bytes stored.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is dropped.
REQ-013 SHALL have port clear_overflow, input, 1 bit: synchronous clear for overflow and drop_count.
REQ-014 SHALL have port drop_count, output, 8 bits: saturating count of dropped bytes.

Function
REQ-015 SHALL pass spi_sck, spi_mosi and spi_cs_n each through SYNC_STAGES flops; all further logic SHALL use only the synchronized versions.
REQ-016 SHALL detect an SCK rise as sync_sck=1 while the previous sample was 0, qualified by sync_cs_n=0.
REQ-017 On each qualified SCK rise, SHALL shift sync_mosi into an 8-bit shift register LSB-side (MSB first on the wire) and increment a 3-bit bit counter.
REQ-018 When the qualified rise completes bit 8, SHALL register the assembled byte and raise an internal push strobe for exactly one cycle (the next clk cycle); the bit counter SHALL wrap to 0.
REQ-019 SHALL reset the bit counter and discard the partial byte while sync_cs_n=1; a partial frame aborted by CS deassertion SHALL push nothing.
REQ-020 FIFO: circular buffer, read/write pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0; fill_level held as a separate counter.
REQ-021 out_byte SHALL be the registered head entry, out_valid = (fill_level != 0); out_byte SHALL be stable while out_valid=1 and next=0.
REQ-022 next with out_valid=1 SHALL advance the read pointer; the new head or out_valid=0 SHALL be visible the following cycle.
REQ-023 next with out_valid=0 SHALL be ignored; no pointer or level change.
REQ-024 A push with fill_level<DEPTH SHALL write at the write pointer; out_valid SHALL rise the cycle after the push when the FIFO was empty.
REQ-025 A simultaneous push and valid pop SHALL both take effect with fill_level unchanged, including when full.
REQ-026 A push when full without a pop SHALL drop the byte, set overflow=1 and increment drop_count, saturating at 255; FIFO contents SHALL be unchanged.
REQ-027 clear_overflow SHALL zero overflow and drop_count next cycle; a drop in the same cycle SHALL take priority (overflow=1, drop_count=1).

Reset
REQ-028 reset=0 SHALL immediately clear: pointers, fill_level=0, out_valid=0, out_byte=0, overflow=0, drop_count=0, bit counter, shift register, push strobe; synchronizers SHALL reset to sck=0, mosi=0, cs_n=1.
REQ-029 Reset deasserted mid-frame SHALL start with an empty FIFO; bits of the interrupted frame SHALL be discarded until spi_cs_n is seen high.

Verification
REQ-030 Single byte: CS low, shift 0xA5 at sck=clk/8, CS high -> out_valid rises, out_byte=0xA5, fill_level=1; next pulse -> out_valid=0, fill_level=0.
REQ-031 Burst: bytes 0x01..0x05 with no pops -> fill_level=5; five next pulses, each 2 cycles apart, -> out_byte sequence 0x01..0x05 in order, then out_valid=0.
REQ-032 Overflow (DEPTH=16): 18 bytes with no pops -> fill_level=16, overflow=1, drop_count=2, head=first byte; clear_overflow -> overflow=0, drop_count=0.
REQ-033 Abort: CS low, 5 bits, CS high, then full byte 0x3C -> exactly one entry, 0x3C.
REQ-034 Full plus simultaneous push/pop: FIFO full, next aligned with push strobe -> fill_level stays 16, overflow stays 0, new byte appears last after 16 pops.
REQ-035 Async reset: assert reset=0 with fill_level=7 mid-frame, outputs zero before next clk edge; release, then send 0x7E -> only 0x7E in FIFO.
